// File: rtl/data_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_pkg
// Shared definitions for the data-memory controller: the data width, the CPU
// access-size encodings, the controller FSM state codes, the port identifiers
// and the CPU alignment-fault rule.
// -----------------------------------------------------------------------------
package data_mem_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_DONE
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_e;

  // A CPU access faults on the reserved size or on a misaligned half/word.
  function automatic logic cpu_fault(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      SIZE_RSVD: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// -----------------------------------------------------------------------------
// mem_lane_unit
// Combinational lane logic for a big-endian 32-bit word memory.
//   i_size, i_offset : access size and byte offset within the word
//   i_sext           : sign-extend sub-word loads
//   i_rd_word        : word read from RAM (load path)
//   i_old_word       : word captured before a sub-word store (merge path)
//   i_wdata          : right-justified store data
//   o_load_data      : selected lane, zero/sign extended (full word for words)
//   o_merged_word    : i_old_word with the addressed lane replaced
// -----------------------------------------------------------------------------
module mem_lane_unit
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_offset,
  input  logic              i_sext,
  input  logic [DATA_W-1:0] i_rd_word,
  input  logic [DATA_W-1:0] i_old_word,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_byte        = 8'h00;
    w_half        = 16'h0000;
    o_load_data   = i_rd_word;
    o_merged_word = i_wdata;

    // Big-endian: offset 0 is the most significant byte / half.
    case (i_offset)
      2'd0:    w_byte = i_rd_word[31:24];
      2'd1:    w_byte = i_rd_word[23:16];
      2'd2:    w_byte = i_rd_word[15:8];
      default: w_byte = i_rd_word[7:0];
    endcase
    w_half = i_offset[1] ? i_rd_word[15:0] : i_rd_word[31:16];

    case (i_size)
      SIZE_BYTE: o_load_data = {{24{i_sext & w_byte[7]}}, w_byte};
      SIZE_HALF: o_load_data = {{16{i_sext & w_half[15]}}, w_half};
      default:   o_load_data = i_rd_word;
    endcase

    case (i_size)
      SIZE_BYTE: begin
        o_merged_word = i_old_word;
        case (i_offset)
          2'd0:    o_merged_word[31:24] = i_wdata[7:0];
          2'd1:    o_merged_word[23:16] = i_wdata[7:0];
          2'd2:    o_merged_word[15:8]  = i_wdata[7:0];
          default: o_merged_word[7:0]   = i_wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        o_merged_word = i_old_word;
        if (i_offset[1]) o_merged_word[15:0]  = i_wdata[15:0];
        else             o_merged_word[31:16] = i_wdata[15:0];
      end
      default: o_merged_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Two-port (CPU + loader) controller in front of a 32-bit word RAM with
// combinational read. Round-robin arbitration, byte/half/word CPU accesses with
// big-endian lanes, read-modify-write for sub-word stores, CPU alignment faults.
//   clk, rst (sync, active low)
//   cpu_req/we/size/sext/addr/wdata -> cpu_rdata/ready/err
//   ldr_req/we/addr/wdata           -> ldr_rdata/ready   (word only)
//   mem_ce/we/addr/wtData, mem_rdData : RAM side
// -----------------------------------------------------------------------------
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sext,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ready,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wtData,
  input  logic [DATA_W-1:0] mem_rdData
);

  state_e             r_state;
  state_e             w_next_state;
  port_e              r_port;
  port_e              r_prio;       // port that wins the next tie
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_sext;
  logic               r_err;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rmw_word;
  logic [DATA_W-1:0]  r_cpu_rdata;
  logic [DATA_W-1:0]  r_ldr_rdata;

  logic               w_grant_cpu;
  logic               w_grant_ldr;
  logic               w_cpu_fault;
  logic [DATA_W-1:0]  w_load_data;
  logic [DATA_W-1:0]  w_merged_word;

  assign w_cpu_fault = cpu_fault(cpu_size, cpu_addr[1:0]);

  mem_lane_unit u_lane (
    .i_size       (r_size),
    .i_offset     (r_addr[1:0]),
    .i_sext       (r_sext),
    .i_rd_word    (mem_rdData),
    .i_old_word   (r_rmw_word),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merged_word(w_merged_word)
  );

  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wtData = w_merged_word;   // word stores pass wdata through the merge
  assign cpu_rdata  = r_cpu_rdata;
  assign ldr_rdata  = r_ldr_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_cpu  = 1'b0;
    w_grant_ldr  = 1'b0;
    mem_ce       = 1'b0;
    mem_we       = 1'b0;
    cpu_ready    = 1'b0;
    ldr_ready    = 1'b0;
    cpu_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_cpu = cpu_req && (!ldr_req || r_prio == PORT_CPU);
        w_grant_ldr = ldr_req && !w_grant_cpu;
        if (w_grant_cpu && w_cpu_fault)                           w_next_state = ST_DONE;
        else if (w_grant_cpu && cpu_we && cpu_size != SIZE_WORD)  w_next_state = ST_RMW_RD;
        else if (w_grant_cpu || w_grant_ldr)                      w_next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_ce       = 1'b1;
        mem_we       = r_we;
        w_next_state = ST_DONE;
      end
      ST_RMW_RD: begin
        mem_ce       = 1'b1;
        w_next_state = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_ce       = 1'b1;
        mem_we       = 1'b1;
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        cpu_ready    = (r_port == PORT_CPU);
        ldr_ready    = (r_port == PORT_LDR);
        cpu_err      = (r_port == PORT_CPU) && r_err;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Control and result registers: cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_port      <= PORT_CPU;
      r_prio      <= PORT_CPU;
      r_err       <= 1'b0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else begin
      if (w_grant_cpu) begin
        r_port <= PORT_CPU;
        r_prio <= PORT_LDR;
        r_err  <= w_cpu_fault;
        if (w_cpu_fault) r_cpu_rdata <= '0;   // a fault completes with zero data
      end else if (w_grant_ldr) begin
        r_port <= PORT_LDR;
        r_prio <= PORT_CPU;
        r_err  <= 1'b0;
      end
      if (r_state == ST_ACCESS && !r_we) begin
        if (r_port == PORT_CPU) r_cpu_rdata <= w_load_data;
        else                    r_ldr_rdata <= w_load_data;
      end
    end
  end

  // NOTE: request payload and the RMW buffer are always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_grant_cpu) begin
      r_we    <= cpu_we;
      r_size  <= cpu_size;
      r_sext  <= cpu_sext;
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
    end else if (w_grant_ldr) begin
      r_we    <= ldr_we;
      r_size  <= SIZE_WORD;
      r_sext  <= 1'b0;
      r_addr  <= ldr_addr;
      r_wdata <= ldr_wdata;
    end
    if (r_state == ST_RMW_RD) r_rmw_word <= mem_rdData;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl: word RAM model, table of directed CPU
// vectors, hand-written loader/reset/arbitration sequences, then random single
// transactions checked against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_sext;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic        ldr_req, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        ldr_ready;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wtData, mem_rdData;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wtData(mem_wtData), .mem_rdData(mem_rdData)
  );

  // Word RAM: 64 words, combinational read, write on posedge with ce=we=1.
  logic [31:0] ram [0:63];
  logic        ram_clear;
  assign mem_rdData = ram[mem_addr[7:2]];
  always @(posedge clk) begin
    if (ram_clear) for (int i = 0; i < 64; i++) ram[i] <= '0;
    else if (mem_ce && mem_we) ram[mem_addr[7:2]] <= mem_wtData;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: byte-addressed big-endian memory plus last result per port.
  logic [7:0]  m_bytes [0:255];
  logic [31:0] m_rd    [0:1];

  task automatic model_op(input bit port, input bit we, input logic [1:0] size_in,
                          input bit sext_in, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] e_rd, output bit e_err, output int e_lat);
    int     a, n;
    int     size;
    bit     sext;
    longint val;
    a    = int'(addr[7:0]);
    size = int'(size_in);
    sext = sext_in;
    if (port) begin
      size = 2;
      sext = 0;
      a    = a - (a % 4);
    end
    e_err = 0;
    e_lat = 2;
    if (!port && (size == 3 || (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0))) begin
      e_err   = 1;
      e_lat   = 1;
      m_rd[0] = '0;
    end else begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) m_bytes[a + i] = 8'(wdata >> (8 * (n - 1 - i)));
        e_lat = (n == 4) ? 2 : 3;
      end else begin
        val = 0;
        for (int i = 0; i < n; i++) val = val * 256 + longint'(m_bytes[a + i]);
        if (sext && n < 4 && val >= (64'd1 << (8 * n - 1))) val = val - (64'd1 << (8 * n));
        m_rd[port] = 32'(val);
      end
    end
    e_rd = m_rd[port];
  endtask

  // One transaction on one port; returns what the DUT showed at completion.
  task automatic do_op(input bit port, input bit we, input logic [1:0] size, input bit sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output bit err, output int lat,
                       output bit ce_seen, output bit other_rdy, output bit extra_rdy);
    bit done = 0;
    @(negedge clk);
    if (!port) begin
      cpu_req = 1; cpu_we = we; cpu_size = size; cpu_sext = sext; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
    end
    rd = '0; err = 0; lat = 0; ce_seen = 0; other_rdy = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (mem_ce) ce_seen = 1;
      if (port ? cpu_ready : ldr_ready) other_rdy = 1;
      if (port ? ldr_ready : cpu_ready) begin
        done = 1;
        rd   = port ? ldr_rdata : cpu_rdata;
        err  = cpu_err;
      end
    end
    if (!done) lat = 99;
    cpu_req = 0;
    ldr_req = 0;
    @(posedge clk); #1;
    extra_rdy = cpu_ready | ldr_ready;
  endtask

  task automatic run_chk(input string nm, input bit port, input bit we, input logic [1:0] size,
                         input bit sext, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    logic [31:0] rd;
    bit err, ce_seen, other_rdy, extra_rdy;
    int lat;
    do_op(port, we, size, sext, addr, wdata, rd, err, lat, ce_seen, other_rdy, extra_rdy);
    check({nm, "_rdata"},       rd, exp_rd);
    check({nm, "_err"},         32'(err), 32'(exp_err));
    check({nm, "_latency"},     32'(lat), 32'(exp_lat));
    check({nm, "_mem_ce_used"}, 32'(ce_seen), 32'(!exp_err));
    check({nm, "_other_ready"}, 32'(other_rdy), 32'd0);
    check({nm, "_ready_width"}, 32'(extra_rdy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
    check({nm, "_ldr_ready"}, 32'(ldr_ready), 32'd0);
    check({nm, "_cpu_err"},   32'(cpu_err),   32'd0);
    check({nm, "_mem_ce"},    32'(mem_ce),    32'd0);
    check({nm, "_mem_we"},    32'(mem_we),    32'd0);
    check({nm, "_cpu_rdata"}, cpu_rdata,      32'd0);
    check({nm, "_ldr_rdata"}, ldr_rdata,      32'd0);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [14];
  int          grants [$];
  int          cyc;
  logic [31:0] e_rd, r_addr, r_wdata;
  bit          e_err, r_port, r_we, r_sext;
  int          e_lat;
  logic [1:0]  r_size;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // CPU vectors: {we, size, sext, addr, wdata, exp rdata, exp err, exp latency}
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h00000000, 1'b0, 2};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'h00000022, 1'b0, 2};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB, 32'h00000022, 1'b0, 3};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFFAB44, 1'b0, 2};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'h00000000, 1'b1, 1};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1122AB44, 1'b0, 2};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'h000000AB, 1'b0, 2};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        32'hFFFFFFAB, 1'b0, 2};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF8001, 32'hFFFFFFAB, 1'b0, 3};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h16, 32'h0,        32'h00008001, 1'b0, 2};
    vecs[10] = '{1'b0, 2'b10, 1'b1, 32'h14, 32'h0,        32'h00008001, 1'b0, 2};
    vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h13, 32'h0,        32'h00000000, 1'b1, 1};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h00000000, 1'b1, 1};
    vecs[13] = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000044, 1'b0, 2};

    cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_sext = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    rst = 0; ram_clear = 1;
    for (int i = 0; i < 256; i++) m_bytes[i] = 8'h00;
    m_rd[0] = '0; m_rd[1] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1; ram_clear = 0;

    // Directed CPU table.
    for (int i = 0; i < 14; i++) begin
      model_op(1'b0, vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
               e_rd, e_err, e_lat);
      run_chk($sformatf("tbl%0d", i), 1'b0, vecs[i].we, vecs[i].size, vecs[i].sext,
              vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);
    end
    check("ram_word_10", ram[4], 32'h1122AB44);
    check("ram_word_14", ram[5], 32'h00008001);

    // Loader write with unaligned address bits, then read back through the loader.
    model_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h23, 32'hDEADBEEF, e_rd, e_err, e_lat);
    run_chk("ldr_wr", 1'b1, 1'b1, 2'b00, 1'b0, 32'h23, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("ram_word_20", ram[8], 32'hDEADBEEF);
    model_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, e_rd, e_err, e_lat);
    run_chk("ldr_rd", 1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Reset while a byte store sits in its read phase.
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_size = 2'b00; cpu_sext = 0; cpu_addr = 32'h11; cpu_wdata = 32'h55;
    @(posedge clk); #1;
    check("abort_rmw_rd_ce", 32'(mem_ce), 32'd1);
    check("abort_rmw_rd_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 0; cpu_req = 0;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    check("abort_ram_intact", ram[4], 32'h1122AB44);
    m_rd[0] = '0; m_rd[1] = '0;
    @(posedge clk); #1;
    check("abort_no_late_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    rst = 1;

    // Both ports request continuously: expect CPU, LDR, CPU, LDR.
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_size = 2'b10; cpu_sext = 0; cpu_addr = 32'h10;
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h14;
    grants.delete();
    cyc = 0;
    while (grants.size() < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ready) grants.push_back(0);
      if (ldr_ready) grants.push_back(1);
    end
    cpu_req = 0; ldr_req = 0;
    @(posedge clk); #1;
    check("arb_completions", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("arb_grant%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'd2, 32'(i % 2));
    model_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e_rd, e_err, e_lat);
    check("arb_cpu_rdata", cpu_rdata, e_rd);
    model_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, e_rd, e_err, e_lat);
    check("arb_ldr_rdata", ldr_rdata, e_rd);

    // Random single transactions against the byte model.
    for (int k = 0; k < 150; k++) begin
      r_port  = ($urandom_range(0, 3) == 0);
      r_we    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_sext  = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 255));
      r_wdata = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_size == 2'b01) r_addr[0]   = 1'b0;
        if (r_size == 2'b10) r_addr[1:0] = 2'b00;
      end
      model_op(r_port, r_we, r_size, r_sext, r_addr, r_wdata, e_rd, e_err, e_lat);
      run_chk($sformatf("rnd%0d", k), r_port, r_we, r_size, r_sext, r_addr, r_wdata,
              e_rd, e_err, e_lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning width of every address port.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on posedge.
REQ-003 SHALL have port rst  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 SHALL have ports cpu_req in 1 and cpu_we in 1: CPU access request and store flag.
REQ-005 SHALL have ports cpu_size in 2 and cpu_sext in 1: access size (00 byte, 01 half, 10 word, 11 reserved) and sign-extend flag for loads.
REQ-006 SHALL have ports cpu_addr in ADDR_W and cpu_wdata in 32: byte address and store data, right-justified for sub-word stores.
REQ-007 SHALL have ports cpu_rdata out 32, cpu_ready out 1 and cpu_err out 1: load result, one-cycle completion pulse, and fault flag valid with ready.
REQ-008 SHALL have ports ldr_req in 1, ldr_we in 1, ldr_addr in ADDR_W and ldr_wdata in 32: loader/debug port, word-only.
REQ-009 SHALL have ports ldr_rdata out 32 and ldr_ready out 1: loader result and one-cycle completion pulse.
REQ-010 SHALL have ports mem_ce out 1, mem_we out 1, mem_addr out ADDR_W, mem_wtData out 32 and mem_rdData in 32, connecting to the word RAM (combinational read; write on posedge while ce=we=1).

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RMW_RD, RMW_WR, DONE.
REQ-012 SHALL in IDLE grant one requesting port, latch its addr, wdata, we, size and sext on the edge, then go to ACCESS (word access or any load), RMW_RD (byte/half store) or DONE with err (fault).
REQ-013 SHALL arbitrate round-robin when both ports request in IDLE (grant the port not granted last); after reset, CPU wins the first tie.
REQ-014 SHALL flag a CPU fault for size 11, half with addr[0]=1, or word with addr[1:0]!=00: no memory cycle, cpu_err=1, cpu_rdata=0, cpu_ready on the cycle after acceptance.
REQ-015 SHALL drive mem_addr from the latched address with bits [1:0] forced to 00; loader address bits [1:0] are ignored and never fault.
REQ-016 SHALL drive mem_ce=1 only in ACCESS, RMW_RD and RMW_WR; mem_we=1 only in ACCESS-store and RMW_WR; otherwise ce=we=0.
REQ-017 SHALL treat memory words as big-endian: byte offset 0 = bits [31:24]; half offset 0 = bits [31:16].
REQ-018 SHALL on loads register the selected lane from mem_rdData at the ACCESS exit edge, zero- or sign-extended per cpu_sext; word loads ignore cpu_sext.
REQ-019 SHALL on byte/half stores capture mem_rdData in RMW_RD, and in RMW_WR write that word with only the addressed lane replaced by the low bits of wdata.
REQ-020 SHALL assert exactly one ready (granted port) for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL give latency from acceptance edge to ready: word/load 2 cycles, sub-word store 3 cycles, fault 1 cycle.
REQ-022 SHALL require a requester to hold req and its operands stable until ready; a req still high in the IDLE cycle after DONE is a new request.
REQ-023 SHALL hold cpu_rdata and ldr_rdata until the next completion on the same port; store completions leave them unchanged.

Reset
REQ-024 SHALL on a rst=0 edge force IDLE, cpu_rdata=ldr_rdata=0, cpu_ready=ldr_ready=cpu_err=0, mem_ce=mem_we=0 and round-robin pointer=CPU.
REQ-025 SHALL abort any in-flight access on reset without a ready pulse; a RAM write already presented on the reset edge may complete, and this is accepted.

Structure
REQ-026 SHALL place the size encodings, FSM state codes and the 32-bit data width in the shared data-memory include file.
REQ-027 SHALL use one combinational sub-module, mem_lane_unit, for lane extract/extend and lane merge.

Verification
REQ-028 SHALL verify: CPU store word 0x11223344 @0x10, then load byte @0x11 with sext=1 -> cpu_rdata=0x00000022 with ready 2 cycles after acceptance.
REQ-029 SHALL verify: store byte 0xAB @0x12 over 0x11223344 -> RAM word 0x1122AB44, ready 3 cycles after acceptance; load half @0x12 with sext=1 -> 0xFFFFAB44.
REQ-030 SHALL verify: load word @0x06 -> cpu_err=1, cpu_rdata=0, ready 1 cycle after acceptance, mem_ce never high.
REQ-031 SHALL verify: both ports request continuously -> grants alternate CPU, LDR, CPU, LDR; no port waits more than one transaction.
REQ-032 SHALL verify: rst=0 during RMW_RD -> next cycle IDLE, no ready, mem_ce=0, outputs zero.
REQ-033 SHALL verify: loader write 0xDEADBEEF @0x23 -> RAM word @0x20 = 0xDEADBEEF, ldr_ready 2 cycles after acceptance.
